pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline stall controller for the five-stage core. It merges stall requests from ID, EX and MEM into the 6-bit `stall` vector consumed by the PC register and every inter-stage register, including the EX/MEM register. It also sequences the multi-cycle divider through a start/ready handshake, holding EX and earlier stages until the quotient is ready. A saturating stall-cycle counter and a sticky divider-timeout flag support performance and debug visibility.

## Interface

Parameters:
- `DIV_TIMEOUT`, default 40: maximum DIV_BUSY cycles before `div_err` sets.
- `CNT_W`, default 16: width of `stall_cycles`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high (`RstEnable` = 1).
- `stallreq_id`  in  1  ID needs a hold (load-use).
- `stallreq_ex`  in  1  EX needs a hold (multi-cycle non-divide op).
- `stallreq_mem`  in  1  MEM waiting on the data bus.
- `div_req`  in  1  EX holds a divide instruction. Stays high while the instruction sits in EX.
- `div_ready_i`  in  1  divider result valid. Level signal, held until the next start.
- `cnt_clr`  in  1  clears `stall_cycles` synchronously.
- `div_start_o`  out  1  one-cycle pulse that launches the divider.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. 1 = `Stop`.
- `stall_cycles`  out  CNT_W  count of cycles with `stall[0]` = 1, saturating.
- `div_err`  out  1  sticky: divider exceeded `DIV_TIMEOUT`.

## Operation

**Divider FSM** (registered state): IDLE, DIV_BUSY, DIV_DONE.
- **IDLE**:
  - If `div_req` = 1 and `stallreq_mem` = 0: assert `div_start_o` combinationally this cycle, then go to DIV_BUSY.
  - If `div_req` = 1 and `stallreq_mem` = 1: no start; stay in IDLE.
- **DIV_BUSY**:
  - Go to DIV_DONE when `div_ready_i` = 1.
  - The busy counter increments each cycle. When it reaches `DIV_TIMEOUT` with no ready, set `div_err`; the FSM keeps waiting.
- **DIV_DONE**:
  - No divide hold in this state, so EX captures the result.
  - Return to IDLE when `stall[3]` = 0.
  - Stay in DIV_DONE while MEM stalls, so the divider is never restarted for the same instruction.
- The busy counter clears on entry to DIV_BUSY.

**div_hold** (combinational):
- 1 in IDLE when `div_req` = 1.
- 1 in DIV_BUSY.
- 0 in DIV_DONE.

**Stall vector** (combinational, priority high to low):
- `stallreq_mem` → 6'b011111
- `stallreq_ex` or `div_hold` → 6'b001111
- `stallreq_id` → 6'b000111
- otherwise → 6'b000000
- The stall is always a contiguous run of 1s from bit0. WB (bit5) is never stalled.
- The EX/MEM register's bubble insertion relies on `stall[3]` = 1 with `stall[4]` = 0 under EX and divide holds.

**stall_cycles**:
- Increments when `stall[0]` = 1.
- Saturates at all-ones and never wraps.
- `cnt_clr` takes priority over the increment; the counter is 0 on the next edge.

## Timing

- Reset (while `rst` = 1, and on the following edge):
  - FSM goes to IDLE and the busy counter to 0.
  - `stall` is forced to 0 and `div_start_o` to 0.
  - `stall_cycles` = 0 and `div_err` = 0.
- Reset asserted mid-divide abandons the operation. After reset, the FSM restarts the divider if `div_req` is still high.
- Stall latency is zero cycles: requests are reflected in `stall` in the same cycle.
- Divide sequence, with T = `div_start_o` cycle and N = divider latency:
  - `stall`[3:0] = 1111 from T through the cycle `div_ready_i` is first seen high.
  - The next cycle is DIV_DONE with `stall` = 0, unless another request is active.
  - EX stall length is N+1 cycles.
- `div_start_o` is high for exactly one cycle per divide instruction.
- Simultaneous `div_ready_i` and `stallreq_mem` in DIV_BUSY: go to DIV_DONE; `stall` = 011111 from MEM priority. Hold DIV_DONE until MEM releases.
- `div_err` stays high until `rst`.
- `stall_cycles` lags `stall` by one edge.

## Test plan

1. **Reset**: hold `rst` 2 cycles with all requests high.
   - Outputs 0 during reset; `stall_cycles` = 0 after reset.
   - First cycle after release: `stall` = 011111, `div_start_o` = 1 is suppressed by MEM.
2. **Priority**: drive id / ex / mem one-hot, then all together.
   - Expect `stall` = 000111, 001111, 011111, then 011111 for all together.
3. **Divide**: `div_req` high, `div_ready_i` rising 34 cycles after start.
   - One `div_start_o` pulse.
   - `stall` = 001111 for 35 cycles, then 000000 in DIV_DONE, then IDLE.
4. **Divide plus MEM stall**: assert `stallreq_mem` for 3 cycles starting the cycle `div_ready_i` rises.
   - FSM held in DIV_DONE for 3 cycles.
   - No second `div_start_o` while `div_req` stays high.
5. **Timeout**: `div_ready_i` never rises, `DIV_TIMEOUT` = 40.
   - `div_err` sets after 40 busy cycles and stays set.
   - `stall` remains 001111.
   - Reset mid-BUSY clears everything.
6. **Counter**: `CNT_W` = 4, continuous `stallreq_id`.
   - `stall_cycles` reaches 15 and holds.
   - `cnt_clr` → 0 next edge, then resumes counting.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Merges the ID/EX/MEM hold requests into the 6-bit stall vector used by
//   the PC register and every inter-stage register. It also runs the
//   multi-cycle divider through a start/ready handshake. It keeps a
//   saturating count of stalled cycles and a sticky divider-timeout flag.
//
// Ports
//   clk           core clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   stallreq_id   ID hold request (load-use)
//   stallreq_ex   EX hold request (multi-cycle non-divide op)
//   stallreq_mem  MEM hold request (data bus wait)
//   div_req       a divide instruction is sitting in EX
//   div_ready_i   divider result valid (level, held until the next start)
//   cnt_clr       synchronous clear of stall_cycles
//   div_start_o   one-cycle divider launch pulse
//   stall         bit0 PC .. bit5 WB, 1 = stop; always a run of 1s from bit0
//   stall_cycles  saturating count of cycles with stall[0] = 1
//   div_err       sticky: divider stayed busy for DIV_TIMEOUT cycles
module pipe_stall_ctrl #(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             div_req,
  input  logic             div_ready_i,
  input  logic             cnt_clr,
  output logic             div_start_o,
  output logic [5:0]       stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             div_err
);

  localparam int BW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BW-1:0]    r_busy_cnt;
  logic             r_div_err;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_div_hold;
  logic             w_div_start;
  logic [5:0]       w_stall;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [BW-1:0] sat_inc_busy(input logic [BW-1:0] v);
    return (v == BW'(DIV_TIMEOUT)) ? v : v + BW'(1);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (div_req && !stallreq_mem) w_state_nxt = S_BUSY;
      S_BUSY: if (div_ready_i)              w_state_nxt = S_DONE;
      // Leave only once EX is free to advance, so a MEM stall cannot cause
      // a second launch for the same divide instruction.
      S_DONE: if (!w_stall[3])              w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_div_hold  = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_hold  = div_req;
        w_div_start = div_req & ~stallreq_mem;
      end
      S_BUSY:  w_div_hold = 1'b1;
      default: ;
    endcase
  end

  // Priority merge. EX-level holds stop bit3 but leave bit4 clear so the
  // EX/MEM register inserts a bubble behind the held instruction.
  always_comb begin
    w_stall = 6'b000000;
    if (stallreq_mem)                   w_stall = 6'b011111;
    else if (stallreq_ex || w_div_hold) w_stall = 6'b001111;
    else if (stallreq_id)               w_stall = 6'b000111;
    if (rst)                            w_stall = 6'b000000;
  end

  assign stall       = w_stall;
  assign div_start_o = w_div_start & ~rst;

  // Busy-cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cnt <= '0;
      r_div_err  <= 1'b0;
    end else if (r_state == S_IDLE && w_state_nxt == S_BUSY) begin
      r_busy_cnt <= '0;
    end else if (r_state == S_BUSY && !div_ready_i) begin
      r_busy_cnt <= sat_inc_busy(r_busy_cnt);
      if (sat_inc_busy(r_busy_cnt) == BW'(DIV_TIMEOUT)) r_div_err <= 1'b1;
    end
  end

  // Stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)  r_stall_cycles <= '0;
    else if (w_stall[0]) r_stall_cycles <= sat_inc_cnt(r_stall_cycles);
  end

  assign stall_cycles = r_stall_cycles;
  assign div_err      = r_div_err;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int TO = 40;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, id, ex, mem, dreq, drdy, clr;
  logic          dstart;
  logic [5:0]    stall;
  logic [CW-1:0] scyc;
  logic          derr;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stallreq_id(id), .stallreq_ex(ex),
    .stallreq_mem(mem), .div_req(dreq), .div_ready_i(drdy), .cnt_clr(clr),
    .div_start_o(dstart), .stall(stall), .stall_cycles(scyc), .div_err(derr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: divide progress (0 none in flight, 1 awaiting result,
  // 2 result delivered), busy-cycle tally, sticky error, stall count.
  int   m_phase = 0;
  int   m_wait  = 0;
  bit   m_err   = 0;
  int   m_cnt   = 0;
  bit   m_init  = 0;
  logic [5:0] e_stall;
  logic       e_start;

  logic [5:0]    last_stall;
  logic          last_start;
  logic [CW-1:0] last_scyc;
  logic          last_derr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_comb();
    bit hold;
    int len;
    hold = (m_phase == 0 && dreq) || m_phase == 1;
    if (mem)              len = 5;
    else if (ex || hold)  len = 4;
    else if (id)          len = 3;
    else                  len = 0;
    e_stall = 6'((1 << len) - 1);
    e_start = (m_phase == 0) && dreq && !mem;
    if (rst) begin
      e_stall = '0;
      e_start = 1'b0;
    end
  endfunction

  function automatic void model_seq();
    if (rst) begin
      m_phase = 0; m_wait = 0; m_err = 0; m_cnt = 0; m_init = 1;
      return;
    end
    if (clr)             m_cnt = 0;
    else if (e_stall[0]) m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
    case (m_phase)
      0: if (e_start) begin m_phase = 1; m_wait = 0; end
      1: if (drdy) m_phase = 2;
         else begin
           m_wait++;
           if (m_wait >= TO) m_err = 1;
         end
      default: if (!e_stall[3]) m_phase = 0;
    endcase
  endfunction

  task automatic set_in(input logic r, input logic i, input logic e, input logic m,
                        input logic dq, input logic dr, input logic c);
    rst = r; id = i; ex = e; mem = m; dreq = dq; drdy = dr; clr = c;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    model_comb();
    last_stall = stall; last_start = dstart; last_scyc = scyc; last_derr = derr;
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".start"}, 32'(dstart), 32'(e_start));
    if (m_init) begin
      chk({tag, ".cycles"}, 32'(scyc), 32'(m_cnt));
      chk({tag, ".err"}, 32'(derr), 32'(m_err));
    end
    @(posedge clk);
    model_seq();
    #1;
  endtask

  typedef struct {
    logic r, i, e, m, dq, dr, c;
    logic [5:0] xs;
    logic       xst;
  } vec_t;

  vec_t tbl[10];
  int   starts, holds;

  initial begin
    set_in(1, 1, 1, 1, 1, 1, 0);
    tbl[0] = '{1, 1, 1, 1, 1, 1, 0, 6'b000000, 1'b0};
    tbl[1] = '{1, 1, 1, 1, 1, 1, 0, 6'b000000, 1'b0};
    tbl[2] = '{0, 1, 1, 1, 1, 1, 0, 6'b011111, 1'b0};
    tbl[3] = '{0, 1, 0, 0, 0, 0, 0, 6'b000111, 1'b0};
    tbl[4] = '{0, 0, 1, 0, 0, 0, 0, 6'b001111, 1'b0};
    tbl[5] = '{0, 0, 0, 1, 0, 0, 0, 6'b011111, 1'b0};
    tbl[6] = '{0, 1, 1, 1, 0, 0, 0, 6'b011111, 1'b0};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 6'b000000, 1'b0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 1, 6'b000000, 1'b0};
    tbl[9] = '{0, 1, 0, 0, 0, 0, 1, 6'b000111, 1'b0};

    // Reset, release with everything high, priority
    for (int k = 0; k < 10; k++) begin
      set_in(tbl[k].r, tbl[k].i, tbl[k].e, tbl[k].m, tbl[k].dq, tbl[k].dr, tbl[k].c);
      step($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d.vec_stall", k), 32'(last_stall), 32'(tbl[k].xs));
      chk($sformatf("tbl%0d.vec_start", k), 32'(last_start), 32'(tbl[k].xst));
    end

    // Divide with ready 34 cycles after start
    starts = 0; holds = 0;
    for (int k = 0; k <= 34; k++) begin
      set_in(0, 0, 0, 0, 1, (k == 34), 0);
      step("div");
      starts += int'(last_start);
      holds  += int'(last_stall == 6'b001111);
    end
    chk("div.start_count", 32'(starts), 32'd1);
    chk("div.hold_len", 32'(holds), 32'd35);
    set_in(0, 0, 0, 0, 1, 1, 0);
    step("div_done");
    chk("div_done.released", 32'(last_stall), 32'd0);
    set_in(0, 0, 0, 0, 0, 1, 0);
    step("div_idle");
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("div_idle2");

    // Divide with MEM stall starting on the ready cycle
    starts = 0;
    for (int k = 0; k <= 5; k++) begin
      set_in(0, 0, 0, (k == 5), 1, (k == 5), 0);
      step("divmem");
      starts += int'(last_start);
    end
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 0, 1, 1, 1, 0);
      step("divmem_hold");
      starts += int'(last_start);
      chk("divmem_hold.stall", 32'(last_stall), 32'h1f);
    end
    set_in(0, 0, 0, 0, 1, 1, 0);
    step("divmem_rel");
    starts += int'(last_start);
    chk("divmem_rel.done_no_hold", 32'(last_stall), 32'd0);
    chk("divmem.start_count", 32'(starts), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("divmem_idle");

    // Timeout, stickiness, reset mid-busy
    set_in(0, 0, 0, 0, 1, 0, 0);
    step("to_start");
    for (int b = 1; b <= 45; b++) begin
      step("to_busy");
      if (b == 40) chk("to.err_b40", 32'(last_derr), 32'd0);
      if (b == 41) chk("to.err_b41", 32'(last_derr), 32'd1);
    end
    set_in(0, 0, 0, 0, 1, 1, 0);
    step("to_ready");
    step("to_done");
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("to_idle");
    chk("to.err_sticky", 32'(last_derr), 32'd1);
    set_in(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) step("rst_busy");
    set_in(1, 0, 0, 0, 1, 0, 0);
    step("rst_mid");
    chk("rst_mid.stall", 32'(last_stall), 32'd0);
    set_in(0, 0, 0, 0, 1, 0, 0);
    step("rst_restart");
    chk("rst_restart.start", 32'(last_start), 32'd1);
    chk("rst_restart.err", 32'(last_derr), 32'd0);
    step("rst_busy2");
    set_in(0, 0, 0, 0, 1, 1, 0);
    step("rst_ready");
    step("rst_done");
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("rst_idle");

    // Saturating counter and clear
    set_in(0, 1, 0, 0, 0, 0, 1);
    step("cnt_clr0");
    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 20; j++) begin
      step("cnt_run");
      chk($sformatf("cnt_run%0d", j), 32'(last_scyc), 32'((j > 15) ? 15 : j));
    end
    set_in(0, 1, 0, 0, 0, 0, 1);
    step("cnt_clr1");
    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      step("cnt_resume");
      chk($sformatf("cnt_resume%0d", j), 32'(last_scyc), 32'(j));
    end

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      set_in($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 19) == 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
